// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, issues one word fetch at a time over req/gnt/rvalid,
// and hands each returned instruction to decode through a valid/ready register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_rvalid,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc_plus4,
    output logic [COUNT_W-1:0] fetch_count
);

    typedef enum logic {S_REQ, S_WAIT} state_e;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          req_addr_q, req_addr_d;
    logic                 drop_q, drop_d;
    logic                 run_q, run_d;
    logic                 id_valid_q, id_valid_d;
    logic [31:0]          id_instr_q, id_instr_d;
    logic [31:0]          id_pc_q, id_pc_d;
    logic [COUNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic                 req;
    logic                 consume;
    logic                 unused_redirect_lsb;

    // Redirect targets are forced to word alignment; the low bits are ignored.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            drop_q        <= 1'b0;
            run_q         <= 1'b0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= 32'h0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            drop_q        <= drop_d;
            run_q         <= run_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        drop_d        = drop_q;
        run_d         = 1'b1;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        fetch_count_d = fetch_count_q;

        // Only request when the output register is guaranteed empty when the
        // response lands, so a response never has to wait for decode.
        req     = run_q && (state_q == S_REQ) && (!id_valid_q || id_ready) && !redirect_valid;
        consume = id_valid_q && id_ready;

        if (consume) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            if (!redirect_valid) begin
                fetch_count_d = fetch_count_q + COUNT_W'(1);
            end
        end

        case (state_q)
            S_REQ: begin
                if (req && imem_gnt) begin
                    req_addr_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (!redirect_valid) begin
                        id_valid_d = 1'b1;
                        id_instr_d = imem_rdata;
                        id_pc_d    = req_addr_q;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_q + 32'd4;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a per-cycle vector table plus a
// hand-written asynchronous reset sequence. A COUNT_W=2 twin checks counter wrap.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NV = 31;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, id_valid, id_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc, id_pc_plus4;
    logic [31:0] fetch_count;
    logic        s_req, s_vld;
    logic [31:0] unused_s_addr, unused_s_instr, unused_s_pc, unused_s_pc4;
    logic [1:0]  s_cnt;

    int n_chk = 0;
    int n_err = 0;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .fetch_count(fetch_count)
    );

    instruction_fetch_unit #(.COUNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(s_req), .imem_addr(unused_s_addr), .imem_gnt(imem_gnt),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(s_vld), .id_ready(id_ready), .id_instr(unused_s_instr),
        .id_pc(unused_s_pc), .id_pc_plus4(unused_s_pc4), .fetch_count(s_cnt)
    );

    function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic rdr, logic [31:0] rp,
                                logic rdy, logic er, logic [31:0] ea, logic ev,
                                logic [31:0] ei, logic [31:0] ep, logic [31:0] ec);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.redir = rdr; v.rpc = rp; v.ready = rdy;
        v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_instr = ei; v.e_pc = ep; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdr, input logic [31:0] rp, input logic rdy);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        redirect_valid = rdr; redirect_pc = rp; id_ready = rdy;
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0,            0, 0, 1,  1, 32'h0,   0, NOP, 0, 0);
        tbl[1]  = mk(0, 1, 32'h00100093, 0, 0, 1,  0, 0,       0, NOP, 0, 0);
        tbl[2]  = mk(1, 0, 0,            0, 0, 1,  1, 32'h4,   1, 32'h00100093, 32'h0, 0);
        tbl[3]  = mk(0, 1, 32'h00200113, 0, 0, 1,  0, 0,       0, NOP, 0, 1);
        tbl[4]  = mk(1, 0, 0,            0, 0, 1,  1, 32'h8,   1, 32'h00200113, 32'h4, 1);
        tbl[5]  = mk(0, 1, 32'h00500093, 0, 0, 1,  0, 0,       0, NOP, 0, 2);
        // decode stalls for five cycles: no request, output held
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 32'h00500093, 32'h8, 2);
        tbl[11] = mk(1, 0, 0,            0, 0, 1,  1, 32'hC,   1, 32'h00500093, 32'h8, 2);
        // redirect in WAIT, wrong-path data two cycles later
        tbl[12] = mk(0, 0, 0,            1, 32'h102, 1,  0, 0, 0, NOP, 0, 3);
        tbl[13] = mk(0, 0, 0,            0, 0, 1,  0, 0,       0, NOP, 0, 3);
        tbl[14] = mk(0, 1, 32'hDEADBEEF, 0, 0, 1,  0, 0,       0, NOP, 0, 3);
        tbl[15] = mk(1, 0, 0,            0, 0, 1,  1, 32'h100, 0, NOP, 0, 3);
        tbl[16] = mk(0, 1, 32'h00300193, 0, 0, 1,  0, 0,       0, NOP, 0, 3);
        tbl[17] = mk(1, 0, 0,            0, 0, 1,  1, 32'h104, 1, 32'h00300193, 32'h100, 3);
        tbl[18] = mk(0, 1, 32'h00400213, 0, 0, 1,  0, 0,       0, NOP, 0, 4);
        // redirect while a valid entry is being accepted: not counted, no request
        tbl[19] = mk(1, 0, 0,            1, 32'h200, 1,  0, 0, 1, 32'h00400213, 32'h104, 4);
        tbl[20] = mk(1, 0, 0,            0, 0, 1,  1, 32'h200, 0, NOP, 0, 4);
        // redirect together with rvalid: data discarded, no pending drop
        tbl[21] = mk(0, 1, 32'hBADC0DE5, 1, 32'h300, 1,  0, 0, 0, NOP, 0, 4);
        tbl[22] = mk(1, 0, 0,            0, 0, 1,  1, 32'h300, 0, NOP, 0, 4);
        tbl[23] = mk(0, 1, 32'h00600313, 0, 0, 1,  0, 0,       0, NOP, 0, 4);
        tbl[24] = mk(0, 0, 0,            0, 0, 1,  1, 32'h304, 1, 32'h00600313, 32'h300, 4);
        tbl[25] = mk(0, 0, 0,            0, 0, 1,  1, 32'h304, 0, NOP, 0, 5);
        // PC wrap at the top of the address space
        tbl[26] = mk(1, 0, 0,            1, 32'hFFFFFFFF, 1,  0, 0, 0, NOP, 0, 5);
        tbl[27] = mk(1, 0, 0,            0, 0, 1,  1, 32'hFFFFFFFC, 0, NOP, 0, 5);
        tbl[28] = mk(0, 1, 32'h00700393, 0, 0, 1,  0, 0,       0, NOP, 0, 5);
        tbl[29] = mk(1, 0, 0,            0, 0, 1,  1, 32'h0,   1, 32'h00700393, 32'hFFFFFFFC, 5);
        tbl[30] = mk(0, 0, 0,            0, 0, 1,  0, 0,       0, NOP, 0, 6);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset imem_req", {31'h0, imem_req}, 32'h0);
        chk("reset id_valid", {31'h0, id_valid}, 32'h0);
        chk("reset id_instr", id_instr, NOP);
        chk("reset id_pc", id_pc, 32'h0);
        chk("reset id_pc_plus4", id_pc_plus4, 32'h4);
        chk("reset fetch_count", fetch_count, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].ready);
            #1;
            chk($sformatf("row%0d imem_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
            chk($sformatf("row%0d w2 imem_req", i), {31'h0, s_req}, {31'h0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d id_valid", i), {31'h0, id_valid}, {31'h0, tbl[i].e_vld});
            chk($sformatf("row%0d w2 id_valid", i), {31'h0, s_vld}, {31'h0, tbl[i].e_vld});
            chk($sformatf("row%0d id_instr", i), id_instr, tbl[i].e_instr);
            if (tbl[i].e_vld) begin
                chk($sformatf("row%0d id_pc", i), id_pc, tbl[i].e_pc);
                chk($sformatf("row%0d id_pc_plus4", i), id_pc_plus4, tbl[i].e_pc + 32'd4);
            end
            chk($sformatf("row%0d fetch_count", i), fetch_count, tbl[i].e_cnt);
            chk($sformatf("row%0d w2 fetch_count", i), {30'h0, s_cnt}, {30'h0, tbl[i].e_cnt[1:0]});
        end

        // Asynchronous reset while a fetch is outstanding
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst fetch_count", fetch_count, 32'h0);
        chk("async rst w2 fetch_count", {30'h0, s_cnt}, 32'h0);
        chk("async rst imem_req", {31'h0, imem_req}, 32'h0);
        chk("async rst id_valid", {31'h0, id_valid}, 32'h0);
        chk("async rst id_pc_plus4", id_pc_plus4, 32'h4);
        drive(1, 1, 32'hDEADBEEF, 0, 0, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(0, 1, 32'hDEADBEEF, 0, 0, 1);
        #1;
        chk("post-rst imem_req", {31'h0, imem_req}, 32'h1);
        chk("post-rst imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1);
        #1;
        chk("stale rvalid id_valid", {31'h0, id_valid}, 32'h0);
        chk("post-rst held imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        drive(0, 1, 32'h00900493, 0, 0, 1);
        #1;
        chk("post-rst wait imem_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("post-rst id_valid", {31'h0, id_valid}, 32'h1);
        chk("post-rst id_instr", id_instr, 32'h00900493);
        chk("post-rst id_pc", id_pc, 32'h0);
        chk("post-rst fetch_count", fetch_count, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the 32-bit RISC-V core. Holds the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Presents each fetched instruction, with its PC, to decode through a valid/ready output register. Decode feeds the instruction word to the immediate generator.
- Accepts branch/jump redirects from execute and discards any in-flight wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on id_instr while id_valid=0 (addi x0,x0,0)
COUNT_W, 32, width of fetched-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch byte address, always word aligned
imem_gnt  in  1  request accepted this cycle
imem_rdata  in  32  returned instruction word
imem_rvalid  in  1  imem_rdata valid; at most one response per granted request, earliest the cycle after gnt
redirect_valid  in  1  branch/jump taken
redirect_pc  in  32  redirect target
id_valid  out  1  id_instr/id_pc hold a valid instruction
id_ready  in  1  decode accepts the output register this cycle
id_instr  out  32  instruction word
id_pc  out  32  PC of id_instr
id_pc_plus4  out  32  id_pc + 4, mod 2^32
fetch_count  out  COUNT_W  instructions handed to decode (id_valid & id_ready), wraps

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=REQ, drop=0, imem_req=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=4, fetch_count=0.
- Single outstanding fetch. FSM states:
  - REQ: imem_req = (!id_valid | id_ready) & !redirect_valid; imem_addr=pc. On req&gnt: pc<=pc+4 (wraps at 2^32), state<=WAIT. No gnt: hold req/addr stable.
  - WAIT: imem_req=0. On rvalid: if drop, discard the data and clear drop; else load id_instr<=imem_rdata, id_pc<=address of the request, id_valid<=1. State<=REQ either way.
- Request is issued only when the output register will be empty at response time, so the response never collides with a held instruction; no skid buffer.
- Minimum latency: gnt in cycle N, rvalid in N+1 gives id_valid in N+2. Best throughput is 1 instruction per 2 cycles.
- Output handshake: id_valid&id_ready consumes the entry (id_valid<=0, id_instr<=NOP_INSTR) unless a response loads in the same edge. id_instr/id_pc stay stable while id_valid&!id_ready.
- Redirect (priority over everything except reset), effective next edge:
  - pc <= {redirect_pc[31:2],2'b00}; id_valid<=0 and id_instr<=NOP_INSTR, even if id_ready is high. The entry is not counted.
  - In WAIT with no rvalid this cycle: drop<=1. In WAIT with rvalid this cycle: that data is discarded and drop stays 0.
  - In REQ: no request is issued that cycle, so no wrong-path grant is possible.
- Back-to-back redirects: the last one wins. drop never exceeds one pending discard, because only one request is ever outstanding.
- fetch_count increments on id_valid&id_ready&!redirect_valid and wraps at 2^COUNT_W-1 -> 0.
- Reset asserted mid-fetch: all state is cleared immediately. An imem_rvalid arriving after reset release with no grant outstanding is ignored.

Test Plan:
- Reset release, memory with gnt=1 and rvalid one cycle later, id_ready=1 -> imem_addr sequence 0x0,0x4,0x8; id_valid pulses every 2nd cycle; id_pc_plus4=id_pc+4; fetch_count=3 after three transfers.
- id_ready=0 for 5 cycles with id_valid=1, instr 0x00500093 -> imem_req=0, id_instr/id_pc stable throughout; after ready=1, next fetch at pc+4.
- Redirect to 0x0000_0102 while in WAIT (rvalid arrives 2 cycles later with 0xDEADBEEF) -> response dropped, id_valid never 1 for it, next imem_addr=0x0000_0100.
- Redirect in the same cycle as rvalid and id_valid=1&id_ready=1 -> output invalidated, data discarded, fetch_count unchanged, next addr=redirect target.
- pc=0xFFFF_FFFC fetch -> id_pc_plus4=0x0000_0000, next imem_addr=0x0000_0000. Also fetch_count=0xFFFF_FFFF plus one transfer -> 0.
- rst_n low asynchronously while in WAIT -> outputs at reset values before the next clk edge; after release, first imem_addr=RESET_PC and a stale rvalid is ignored.
